// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flop, DIFF = A - B - BIN, LSB first.
// Latency: start sampled at edge k, bits processed at edges k+1..k+WIDTH, done pulse in the following cycle.
// Backpressure: none; start is only honoured in IDLE, and is ignored while busy or done.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start, a, b, bin  request and operands, captured together on an accepted start
//   busy              high while bits are being shifted through the cell
//   done              one-cycle completion pulse; diff/bout/ovf valid from this cycle
//   diff, bout, ovf   registered result, unsigned borrow out, signed overflow
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    // Counter only has to reach WIDTH-1.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    // Full-subtractor cell on the current LSBs.
    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        d_bit     = sa_q[0] ^ sb_q[0] ^ br_q;
        br_nxt    = (~sa_q[0] & sb_q[0]) | (~sa_q[0] & br_q) | (sb_q[0] & br_q);
        res_shift = {d_bit, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                res_d = res_shift;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = br_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Last bit: publish the result on the same edge that enters DONE.
                    // The bit being produced now is the result MSB used for ovf.
                    cnt_d   = '0;
                    diff_d  = res_shift;
                    bout_d  = br_nxt;
                    ovf_d   = (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor built around a single full-subtractor cell and a borrow flip-flop; computes DIFF = A - B - BIN, LSB first.
- Complements the combinational full adder in the arithmetic library.
- Used where area matters more than latency (slow control paths, serial ALU experiments).
- Operands are loaded with a start pulse; the result and flags are presented with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous active-low reset
- start  input   1      request; sampled only in IDLE
- a      input   WIDTH  minuend, captured on accepted start
- b      input   WIDTH  subtrahend, captured on accepted start
- bin    input   1      borrow in, captured on accepted start
- busy   output  1      high while bits are being processed
- done   output  1      one-cycle pulse; diff/bout/ovf valid from this cycle
- diff   output  WIDTH  result, A - B - BIN mod 2^WIDTH
- bout   output  1      borrow out (1 when A < B + BIN, unsigned)
- ovf    output  1      two's-complement signed overflow of the subtraction

Behaviour:
- Reset (rst_n low, async): state = IDLE; busy, done, diff, bout and ovf all 0; shift registers, borrow register and bit counter all 0. Takes effect immediately, including mid-operation; the partial result is discarded and no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start = 1 at a clock edge: capture a -> sa, b -> sb, bin -> borrow register, clear the bit counter, go to SHIFT.
  - start = 0: remain in IDLE.
- SHIFT, one bit per clock:
  - d = sa[0] ^ sb[0] ^ br
  - br_next = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br)
  - Shift d into the MSB of the internal result register (shift right).
  - Shift sa and sb right by 1, keeping a copy of the original MSBs of a and b for ovf.
  - Counter increments. On the edge that processes bit WIDTH-1, go to DONE.
  - busy = 1 throughout SHIFT.
- DONE, exactly one cycle:
  - done = 1, busy = 0.
  - diff = internal result; bout = final borrow.
  - ovf = (a_msb != b_msb) & (diff_msb != a_msb).
  - Unconditionally returns to IDLE.
- Latency: start sampled at edge k. Bits are processed at edges k+1 .. k+WIDTH. done is high for the cycle following edge k+WIDTH. The result registers update at that same edge.
- Holding: diff, bout and ovf are registered outputs. They update only on entry to DONE and hold their values through IDLE and any later SHIFT until the next completion.
- start while in SHIFT or DONE is ignored: no restart, no queuing, and operands are not resampled.
- Changes on a, b or bin after the start edge have no effect on the operation in flight.
- Back-to-back: the earliest next accepted start is the edge after the DONE cycle, so throughput is one result per WIDTH+2 cycles.
- Width rules:
  - The counter is wide enough to hold WIDTH-1.
  - No internal value is wider than WIDTH except the borrow bit.
  - bout is equivalent to the carry-out of A + ~B + ~BIN being 0.

Test Plan:
- WIDTH=8; a=100, b=37, bin=0, start pulse -> busy high for 8 cycles, then done for 1 cycle with diff=63, bout=0, ovf=0; done first high in the 9th cycle after the start edge.
- a=5, b=9, bin=0 -> diff=252 (0xFC), bout=1, ovf=0. Then a=0, b=0, bin=1 -> diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- Start accepted with a=200, b=50. Pulse start with a=1, b=1 at cycle 3 and change a/b every cycle -> result still diff=150, bout=0. Only one done pulse appears, and outputs hold 150 until the next completion.
- Drop rst_n for one half-cycle during SHIFT (after 4 bits) -> busy, done, diff, bout and ovf read 0 immediately. No done pulse follows. A fresh start (a=10, b=3) after reset yields diff=7.
- WIDTH=4, exhaustive over all a, b, bin (512 cases), back-to-back starts issued on the first IDLE cycle -> every result matches (a - b - bin) mod 16; bout, ovf and the WIDTH+1 start-to-done latency are checked per case.
